// File: rtl/hyper_evt_pkg.sv
// Shared types and helpers for the hyper EOT classifier slice.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package hyper_evt_pkg;

    typedef enum logic {
        DIR_WRITE = 1'b0,
        DIR_READ  = 1'b1
    } hyper_dir_e;

    // Width needed to hold an occupancy count of 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/hyper_dir_fifo.sv
// Small 1-bit-wide direction FIFO with wrapping pointers and occupancy count.
// Latency: push visible at head/count one cycle later; head is read combinationally.
// Backpressure: push ignored when full unless popping in the same cycle; pop ignored when empty.
module hyper_dir_fifo
    import hyper_evt_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic             push_dat,
    input  logic             pop,
    output logic             empty,
    output logic             full,
    output logic             head,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    // Qualify requests: a full FIFO only accepts a push when a pop frees a slot.
    always_comb begin
        empty   = (count == '0);
        full    = (count == CNT_W'(DEPTH));
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
        head    = mem[rd_ptr];
    end

    // Storage array; contents behind the pointers need no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/hyper_eot_classifier.sv
// Tags each per-channel controller EOT as read-done or write-done in launch order.
// Latency: event pulses, pending counts and flags are registered, one cycle after the inputs.
// Backpressure: none; launches into a full queue are dropped and flagged sticky ovf.
module hyper_eot_classifier
    import hyper_evt_pkg::*;
#(
    parameter int  NB_CH      = 2,
    parameter int  FIFO_DEPTH = 4,
    localparam int CNT_W      = cnt_width(FIFO_DEPTH)
) (
    input  logic                   sys_clk_i,
    input  logic                   rstn_i,
    input  logic [NB_CH-1:0]       rx_evt_i,
    input  logic [NB_CH-1:0]       tx_evt_i,
    input  logic [NB_CH-1:0]       eot_i,
    input  logic                   err_clr_i,
    output logic [NB_CH-1:0]       evt_rd_eot_o,
    output logic [NB_CH-1:0]       evt_wr_eot_o,
    output logic [NB_CH*CNT_W-1:0] pending_o,
    output logic [NB_CH-1:0]       ovf_o,
    output logic [NB_CH-1:0]       udf_o,
    output logic [NB_CH-1:0]       conflict_o
);

    for (genvar c = 0; c < NB_CH; c++) begin : g_ch
        logic             push;
        logic             fifo_push;
        logic             fifo_pop;
        logic             ovf_set;
        logic             udf_set;
        logic             conflict_set;
        hyper_dir_e       push_dir;
        hyper_dir_e       dir;
        hyper_dir_e       last_dir_q;
        logic             empty;
        logic             full;
        logic             head;
        logic [CNT_W-1:0] count;
        logic             rd_q;
        logic             wr_q;
        logic             ovf_q;
        logic             udf_q;
        logic             conflict_q;

        hyper_dir_fifo #(
            .DEPTH (FIFO_DEPTH),
            .CNT_W (CNT_W)
        ) u_fifo (
            .clk      (sys_clk_i),
            .rstn     (rstn_i),
            .push     (fifo_push),
            .push_dat (push_dir),
            .pop      (fifo_pop),
            .empty    (empty),
            .full     (full),
            .head     (head),
            .count    (count)
        );

        // Decode launches, pick the EOT direction (queue head, bypass or last_dir) and error sets.
        always_comb begin
            push         = rx_evt_i[c] ^ tx_evt_i[c];
            push_dir     = rx_evt_i[c] ? DIR_READ : DIR_WRITE;
            conflict_set = rx_evt_i[c] & tx_evt_i[c];
            fifo_pop     = eot_i[c] & ~empty;
            // An EOT on an empty queue consumes a same-cycle launch directly.
            fifo_push    = push & ~(eot_i[c] & empty) & (~full | eot_i[c]);
            ovf_set      = push & full & ~eot_i[c];
            udf_set      = eot_i[c] & empty & ~push;
            dir          = last_dir_q;
            if (eot_i[c]) begin
                if (!empty) begin
                    dir = hyper_dir_e'(head);
                end else if (push) begin
                    dir = push_dir;
                end
            end
        end

        // Registered event pulses, last direction and sticky flags (a new set beats a clear).
        always_ff @(posedge sys_clk_i) begin
            if (!rstn_i) begin
                rd_q       <= 1'b0;
                wr_q       <= 1'b0;
                last_dir_q <= DIR_WRITE;
                ovf_q      <= 1'b0;
                udf_q      <= 1'b0;
                conflict_q <= 1'b0;
            end else begin
                rd_q       <= eot_i[c] & (dir == DIR_READ);
                wr_q       <= eot_i[c] & (dir == DIR_WRITE);
                if (eot_i[c]) last_dir_q <= dir;
                ovf_q      <= ovf_set      | (ovf_q      & ~err_clr_i);
                udf_q      <= udf_set      | (udf_q      & ~err_clr_i);
                conflict_q <= conflict_set | (conflict_q & ~err_clr_i);
            end
        end

        assign evt_rd_eot_o[c]             = rd_q;
        assign evt_wr_eot_o[c]             = wr_q;
        assign pending_o[c*CNT_W +: CNT_W] = count;
        assign ovf_o[c]                    = ovf_q;
        assign udf_o[c]                    = udf_q;
        assign conflict_o[c]               = conflict_q;
    end

endmodule

// File: tb/tb_hyper_eot_classifier.sv
// Self-checking bench for hyper_eot_classifier: directed scenarios followed by random traffic.
// Latency: every driven cycle is checked 1 time unit after the following rising edge.
// Backpressure: n/a.
module tb_hyper_eot_classifier;

    localparam int NB_CH      = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

    logic                   clk = 1'b0;
    logic                   rstn;
    logic [NB_CH-1:0]       rx_evt;
    logic [NB_CH-1:0]       tx_evt;
    logic [NB_CH-1:0]       eot;
    logic                   err_clr;
    logic [NB_CH-1:0]       evt_rd_eot;
    logic [NB_CH-1:0]       evt_wr_eot;
    logic [NB_CH*CNT_W-1:0] pending;
    logic [NB_CH-1:0]       ovf;
    logic [NB_CH-1:0]       udf;
    logic [NB_CH-1:0]       conflict;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: one queue of launched directions per channel (1 = read, 0 = write).
    bit              mq [NB_CH][$];
    bit [NB_CH-1:0]  m_last;
    bit [NB_CH-1:0]  m_rd;
    bit [NB_CH-1:0]  m_wr;
    bit [NB_CH-1:0]  m_ovf;
    bit [NB_CH-1:0]  m_udf;
    bit [NB_CH-1:0]  m_conf;

    hyper_eot_classifier #(
        .NB_CH      (NB_CH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .sys_clk_i    (clk),
        .rstn_i       (rstn),
        .rx_evt_i     (rx_evt),
        .tx_evt_i     (tx_evt),
        .eot_i        (eot),
        .err_clr_i    (err_clr),
        .evt_rd_eot_o (evt_rd_eot),
        .evt_wr_eot_o (evt_wr_eot),
        .pending_o    (pending),
        .ovf_o        (ovf),
        .udf_o        (udf),
        .conflict_o   (conflict)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update(input bit [NB_CH-1:0] rx, input bit [NB_CH-1:0] tx,
                                input bit [NB_CH-1:0] e, input bit clr, input bit rn);
        for (int c = 0; c < NB_CH; c++) begin
            bit d;
            bit pushing;
            pushing = rx[c] ^ tx[c];
            m_rd[c] = 1'b0;
            m_wr[c] = 1'b0;
            if (!rn) begin
                mq[c].delete();
                m_last[c] = 1'b0;
                m_ovf[c]  = 1'b0;
                m_udf[c]  = 1'b0;
                m_conf[c] = 1'b0;
            end else begin
                if (clr) begin
                    m_ovf[c]  = 1'b0;
                    m_udf[c]  = 1'b0;
                    m_conf[c] = 1'b0;
                end
                if (rx[c] && tx[c]) m_conf[c] = 1'b1;
                if (e[c]) begin
                    if (mq[c].size() > 0) begin
                        d = mq[c].pop_front();
                        if (pushing) mq[c].push_back(rx[c]);
                    end else if (pushing) begin
                        d = rx[c];
                    end else begin
                        d = m_last[c];
                        m_udf[c] = 1'b1;
                    end
                    m_last[c] = d;
                    m_rd[c]   = d;
                    m_wr[c]   = ~d;
                end else if (pushing) begin
                    if (mq[c].size() < FIFO_DEPTH) mq[c].push_back(rx[c]);
                    else m_ovf[c] = 1'b1;
                end
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model and compare every output.
    task automatic step(input logic [NB_CH-1:0] rx, input logic [NB_CH-1:0] tx,
                        input logic [NB_CH-1:0] e, input logic clr, input logic rn);
        logic [NB_CH*CNT_W-1:0] exp_pend;
        @(negedge clk);
        rx_evt  = rx;
        tx_evt  = tx;
        eot     = e;
        err_clr = clr;
        rstn    = rn;
        @(posedge clk);
        model_update(rx, tx, e, clr, rn);
        #1;
        for (int c = 0; c < NB_CH; c++) exp_pend[c*CNT_W +: CNT_W] = CNT_W'(mq[c].size());
        check("evt_rd_eot", evt_rd_eot, m_rd);
        check("evt_wr_eot", evt_wr_eot, m_wr);
        check("pending",    pending,    exp_pend);
        check("ovf",        ovf,        m_ovf);
        check("udf",        udf,        m_udf);
        check("conflict",   conflict,   m_conf);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0, '0, 1'b0, 1'b1);
    endtask

    initial begin
        rstn = 1'b0; rx_evt = '0; tx_evt = '0; eot = '0; err_clr = 1'b0;
        m_last = '0; m_rd = '0; m_wr = '0; m_ovf = '0; m_udf = '0; m_conf = '0;

        // Reset state.
        step('0, '0, '0, 1'b0, 1'b0);
        step('0, '0, '0, 1'b0, 1'b0);
        check("rst_pending", pending, 0);

        // 1: read, write, read launches on ch0, then three EOTs.
        step(2'b01, '0, '0, 1'b0, 1'b1);
        idle(1);
        step('0, 2'b01, '0, 1'b0, 1'b1);
        idle(1);
        step(2'b01, '0, '0, 1'b0, 1'b1);
        check("t1_pend3", pending[CNT_W-1:0], 3);
        idle(4);
        step('0, '0, 2'b01, 1'b0, 1'b1);
        check("t1_rd1", evt_rd_eot[0], 1);
        idle(1);
        step('0, '0, 2'b01, 1'b0, 1'b1);
        check("t1_wr", evt_wr_eot[0], 1);
        idle(1);
        step('0, '0, 2'b01, 1'b0, 1'b1);
        check("t1_rd2", evt_rd_eot[0], 1);
        idle(1);

        // 2: five writes on ch1 overflow a depth-4 queue, then drain.
        for (int i = 0; i < 5; i++) step('0, 2'b10, '0, 1'b0, 1'b1);
        check("t2_pend4", pending[2*CNT_W-1:CNT_W], FIFO_DEPTH);
        check("t2_ovf", ovf[1], 1);
        for (int i = 0; i < 4; i++) step('0, '0, 2'b10, 1'b0, 1'b1);
        idle(1);
        check("t2_pend0", pending[2*CNT_W-1:CNT_W], 0);

        // 3: underflow on ch0 reuses the last (read) direction; clear afterwards.
        step('0, '0, 2'b01, 1'b0, 1'b1);
        check("t3_rd", evt_rd_eot[0], 1);
        check("t3_udf", udf[0], 1);
        step('0, '0, '0, 1'b1, 1'b1);
        check("t3_clr", udf, 0);

        // 4: bypass on empty ch1.
        step('0, 2'b10, 2'b10, 1'b0, 1'b1);
        check("t4_wr", evt_wr_eot[1], 1);
        check("t4_pend", pending[2*CNT_W-1:CNT_W], 0);
        check("t4_udf", udf[1], 0);

        // 5: conflict on ch0 while ch1 launches a read; then clear coinciding with a new conflict.
        step(2'b11, 2'b01, '0, 1'b0, 1'b1);
        check("t5_conf", conflict, 2'b01);
        step(2'b01, 2'b01, '0, 1'b1, 1'b1);
        step('0, '0, 2'b10, 1'b1, 1'b1);

        // 6: mid-operation reset discards queued entries; next EOTs fall back to write.
        for (int i = 0; i < 3; i++) step(2'b11 ^ 2'b00, 2'b00, '0, 1'b0, 1'b1);
        step('0, '0, 2'b11, 1'b0, 1'b0);
        step('0, '0, 2'b11, 1'b0, 1'b1);
        check("t6_wr", evt_wr_eot, 2'b11);
        check("t6_udf", udf, 2'b11);
        idle(1);

        // Random traffic: launch-heavy phase, then EOT-heavy phase, with rare clears and resets.
        for (int i = 0; i < 4000; i++) begin
            logic [NB_CH-1:0] r_rx;
            logic [NB_CH-1:0] r_tx;
            logic [NB_CH-1:0] r_eot;
            r_rx  = NB_CH'($urandom) & NB_CH'($urandom);
            r_tx  = NB_CH'($urandom) & NB_CH'($urandom);
            r_eot = (i < 2000) ? (NB_CH'($urandom) & NB_CH'($urandom)) : NB_CH'($urandom);
            step(r_rx, r_tx, r_eot, ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 299) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
